// File: rtl/instr_sequencer_pkg.sv
// Shared control definitions for the RV32I multi-cycle sequencer: opcodes,
// FSM state encoding, ALU control codes and the funct7 legality helper.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  // alu_ctrl = {alt, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // funct7 is either all-zero, or the alternate encoding on ADD/SUB and SRL/SRA slots
  function automatic logic f7_legal(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational field decoder: opcode/funct3/funct7 -> ALU op, operand-B
// select and an illegal-encoding flag. Illegal words decode to ADD/rs2.
module alu_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_imm,
  output logic       illegal_enc
);

  logic f7_ok;
  logic is_shift;

  assign f7_ok    = f7_legal(funct7, funct3);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Classify the opcode and pick the ALU operation for it
  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_src_imm = 1'b0;
    illegal_enc = 1'b0;
    case (opcode)
      OP_R: begin
        if (f7_ok) alu_ctrl = {funct7[5], funct3};
        else       illegal_enc = 1'b1;
      end
      OP_IMM: begin
        if (is_shift && !f7_ok) begin
          illegal_enc = 1'b1;
        end else begin
          alu_ctrl    = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
          alu_src_imm = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: begin
        alu_ctrl    = ALU_ADD;
        alu_src_imm = 1'b1;
      end
      OP_BRANCH: alu_ctrl = ALU_SUB;
      default:   illegal_enc = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I control FSM: fetch over req/ack, decode, sequence
// EXEC/MEM/WB strobes, count retired instructions, trap on bad encodings.
module instr_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  input  logic                 imem_ack,
  input  logic [XLEN-1:0]      imem_rdata,
  output logic [XLEN-1:0]      ir,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic [3:0]           alu_ctrl,
  output logic                 alu_src_imm,
  input  logic                 branch_taken,
  output logic                 rf_we,
  output logic                 wb_sel,
  output logic                 pc_we,
  output logic                 pc_sel_branch,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t     state, state_nx;
  logic [3:0] dec_alu;
  logic       dec_imm, dec_ill;
  logic       is_load, is_store, is_branch, is_alu;
  logic       active_q;   // DECODE..WB: ALU controls are driven
  logic       pc_we_q;    // WB, or EXEC of a branch
  logic       br_exec_q;  // EXEC of a branch

  alu_ctrl_decode u_dec (
    .opcode      (ir[6:0]),
    .funct3      (ir[14:12]),
    .funct7      (ir[31:25]),
    .alu_ctrl    (dec_alu),
    .alu_src_imm (dec_imm),
    .illegal_enc (dec_ill)
  );

  assign is_load   = (ir[6:0] == OP_LOAD);
  assign is_store  = (ir[6:0] == OP_STORE);
  assign is_branch = (ir[6:0] == OP_BRANCH);
  assign is_alu    = (ir[6:0] == OP_R) || (ir[6:0] == OP_IMM);

  // Next-state: acks only matter in the state that owns the matching request
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = FETCH;
      FETCH:  if (imem_ack) state_nx = DECODE;
      DECODE: state_nx = dec_ill ? TRAP : EXEC;
      EXEC: begin
        if (is_alu)         state_nx = WB;
        else if (is_branch) state_nx = FETCH;
        else                state_nx = MEM;
      end
      MEM:    if (dmem_ack) state_nx = is_load ? WB : FETCH;
      WB:     state_nx = FETCH;
      TRAP:   state_nx = TRAP;
      default: state_nx = IDLE;
    endcase
  end

  // Store retires in its ack cycle, so its PC strobe is qualified by dmem_ack;
  // all other strobes come straight from registers.
  assign pc_we         = pc_we_q | (dmem_we & dmem_ack);
  assign pc_sel_branch = br_exec_q & branch_taken;
  assign alu_ctrl      = active_q ? dec_alu : ALU_ADD;
  assign alu_src_imm   = active_q & dec_imm;

  // State, ir, retire counter and strobes registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ir        <= '0;
      instret   <= '0;
      illegal   <= 1'b0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      rf_we     <= 1'b0;
      wb_sel    <= 1'b0;
      pc_we_q   <= 1'b0;
      br_exec_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state     <= state_nx;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      instret   <= instret + INSTRET_W'(pc_we);
      illegal   <= illegal | (state_nx == TRAP);
      imem_req  <= (state_nx == FETCH);
      dmem_req  <= (state_nx == MEM);
      dmem_we   <= (state_nx == MEM) && is_store;
      rf_we     <= (state_nx == WB);
      wb_sel    <= (state_nx == WB) && is_load;
      pc_we_q   <= (state_nx == WB) || (state_nx == EXEC && is_branch);
      br_exec_q <= (state_nx == EXEC) && is_branch;
      active_q  <= (state_nx == DECODE) || (state_nx == EXEC) ||
                   (state_nx == MEM) || (state_nx == WB);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer. The reference model turns each
// instruction into an expected list of phases and derives strobes from it.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata, ir;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  alu_ctrl;
  logic        alu_src_imm, branch_taken, rf_we, wb_sel, pc_we, pc_sel_branch, illegal;
  logic [31:0] instret;

  instr_sequencer #(.XLEN(32), .INSTRET_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .branch_taken(branch_taken),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel_branch(pc_sel_branch),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 5;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_ir;
  logic [31:0] m_ret;
  bit          m_ill;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] obs();
    return {imem_req, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel_branch,
            alu_src_imm, illegal, alu_ctrl};
  endfunction

  // cls: 0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH 5=unknown
  function automatic void classify(input logic [31:0] w, output int cls, output bit bad,
                                   output logic [3:0] alu, output bit imm);
    int f3 = int'(w[14:12]);
    int f7 = int'(w[31:25]);
    bit ok7;
    bad = 0; alu = 4'd0; imm = 0;
    case (int'(w[6:0]))
      'h33: cls = 0;
      'h13: cls = 1;
      'h03: cls = 2;
      'h23: cls = 3;
      'h63: cls = 4;
      default: cls = 5;
    endcase
    ok7 = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
    case (cls)
      0: begin bad = !ok7; alu = 4'((f7 == 32) ? 8 + f3 : f3); end
      1: begin bad = (f3 == 1 || f3 == 5) && !ok7; alu = 4'((f3 == 5 && f7 == 32) ? 13 : f3); imm = 1; end
      2, 3: imm = 1;
      4: alu = 4'd8;
      default: bad = 1;
    endcase
    if (bad) begin alu = 4'd0; imm = 0; end
  endfunction

  task automatic idle_cycle();
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom); branch_taken = 1'($urandom);
    imem_rdata = $urandom;
    #1;
    chk("idle_strobes", 64'(obs()), 64'({8'b0, m_ill, 4'b0}));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom); branch_taken = 1'($urandom);
    #1;
    chk("rst_strobes", 64'(obs()), 64'd0);
    chk("rst_ir", 64'(ir), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    m_ir = '0; m_ret = '0; m_ill = 0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
  endtask

  // Run one instruction from its first FETCH cycle; abort_at >= 0 resets at that phase
  task automatic run_instr(input logic [31:0] w, input int di, input int dm, input bit bt,
                           input int tn, input int abort_at);
    int cls; bit bad, imm, last, act; logic [3:0] alu;
    int ph[$];
    logic [12:0] e;
    classify(w, cls, bad, alu, imm);
    for (int i = 0; i <= di; i++) ph.push_back(PF);
    ph.push_back(PD);
    if (bad) begin
      for (int i = 0; i < tn; i++) ph.push_back(PT);
    end else begin
      ph.push_back(PE);
      if (cls == 2 || cls == 3)
        for (int i = 0; i <= dm; i++) ph.push_back(PM);
      if (cls <= 2) ph.push_back(PW);
    end
    for (int k = 0; k < ph.size(); k++) begin
      int p = ph[k];
      if (k == abort_at) begin
        do_reset();
        return;
      end
      last = (k == ph.size() - 1) || (ph[k+1] != p);
      imem_ack     = (p == PF) ? last : 1'($urandom);
      imem_rdata   = (p == PF && last) ? w : $urandom;
      dmem_ack     = (p == PM) ? last : 1'($urandom);
      branch_taken = (p == PE) ? bt : 1'($urandom);
      #1;
      act = (p == PD || p == PE || p == PM || p == PW);
      e = {p == PF, p == PM, p == PM && cls == 3, p == PW, p == PW && cls == 2,
           (p == PW) || (p == PE && cls == 4) || (p == PM && last && cls == 3),
           p == PE && cls == 4 && bt, act && imm, m_ill, act ? alu : 4'd0};
      chk("strobes", 64'(obs()), 64'(e));
      chk("ir", 64'(ir), 64'(m_ir));
      chk("instret", 64'(instret), 64'(m_ret));
      if (e[7]) m_ret = m_ret + 32'd1;
      if (p == PF && last) m_ir = w;
      if (p == PD && bad) m_ill = 1;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    int r = $urandom_range(0, 19);
    int s = $urandom_range(0, 5);
    logic [6:0] op;
    if (r < 5)       op = 7'h33;
    else if (r < 10) op = 7'h13;
    else if (r < 13) op = 7'h03;
    else if (r < 16) op = 7'h23;
    else if (r < 19) op = 7'h63;
    else begin
      op = 7'($urandom);
      while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63)
        op = 7'($urandom);
    end
    w[6:0] = op;
    if (s < 3)      w[31:25] = 7'h00;
    else if (s < 5) w[31:25] = 7'h20;
    return w;
  endfunction

  initial begin
    imem_ack = 0; dmem_ack = 0; branch_taken = 0; imem_rdata = '0;
    m_ir = '0; m_ret = '0; m_ill = 0;
    @(negedge clk);
    do_reset();
    // add / sub, zero-wait
    run_instr(32'h002081B3, 0, 0, 0, 0, -1);
    chk("add_instret", 64'(instret), 64'd1);
    run_instr(32'h402081B3, 1, 0, 0, 0, -1);
    // lw with late ack, sw, beq taken / not taken
    run_instr(32'h0000A183, 0, 3, 0, 0, -1);
    run_instr(32'h0030A023, 2, 2, 0, 0, -1);
    run_instr(32'h00208463, 0, 0, 1, 0, -1);
    run_instr(32'h00208463, 0, 0, 0, 0, -1);
    chk("dir_instret", 64'(instret), 64'd6);
    // bad funct7 traps and holds
    run_instr(32'h422081B3, 0, 0, 0, 22, -1);
    do_reset();
    // reset mid-MEM with ack withheld, then normal operation resumes
    run_instr(32'h0000A183, 0, 5, 0, 0, 5);
    run_instr(32'h002081B3, 0, 0, 0, 0, -1);
    run_instr(32'hFFFFFFFF, 1, 0, 0, 22, -1);
    do_reset();
    // random mix of encodings and wait states
    for (int n = 0; n < 200; n++) begin
      logic [31:0] w = gen_instr();
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 4, -1);
      if (m_ill) do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
